axi_rd_burst_master: RTL and testbench

Parametrised AXI4 read master. It accepts one read command (start address, byte count) and splits it into INCR bursts. Bursts are capped at MAX_LEN beats, never cross a 4 KB boundary, and up to MAX_OUTSTANDING are kept in flight. Returned data is forwarded as a valid/ready stream with a last flag, and one accumulated response status is reported per command. It sits between DMA/command logic and an AXI interconnect read port.

---
 rtl/axi_rd_burst_master_pkg.sv | 62 ++++++
 rtl/axi_rd_burst_master_burst_calc.sv | 27 ++
 rtl/axi_rd_burst_master.sv | 155 +++++++++++++++
 tb/tb_axi_rd_burst_master.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_burst_master_pkg.sv
// Shared AXI types and helpers used by the burst read master.
// Beat arithmetic is done in widened unsigned math so nothing truncates.
package axi_rd_burst_master_pkg;

  typedef enum logic [2:0] {
    SIZE_1   = 3'd0,
    SIZE_2   = 3'd1,
    SIZE_4   = 3'd2,
    SIZE_8   = 3'd3,
    SIZE_16  = 3'd4,
    SIZE_32  = 3'd5,
    SIZE_64  = 3'd6,
    SIZE_128 = 3'd7
  } AxiSize_t;

  typedef enum logic [1:0] {
    FIXED      = 2'd0,
    INCR       = 2'd1,
    WRAP       = 2'd2,
    BURST_RSVD = 2'd3
  } AxiBurst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } AxiResp_t;

  typedef struct packed {
    logic [63:0] address;
    logic [15:0] bytes;
  } AxiMasterRdCtrl_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StDrain  = 2'd2,
    StStatus = 2'd3
  } AxiRdMasterState_t;

  localparam int unsigned AXI_4K_BOUNDARY = 4096;

  function automatic logic axiSuccess(input AxiResp_t resp);
    return (resp == OKAY) || (resp == EXOKAY);
  endfunction

  // ceil(bytes / 2**size)
  function automatic logic [15:0] axiBeats(input logic [15:0] bytes, input AxiSize_t size);
    logic [16:0] sum;
    sum = {1'b0, bytes} + ((17'd1 << size) - 17'd1);
    return 16'(sum >> size);
  endfunction

  // Beats left before the next 4 KB boundary; address is assumed beat-aligned.
  function automatic logic [12:0] axiBeatsTo4k(input logic [11:0] address, input AxiSize_t size);
    logic [12:0] span;
    span = 13'(AXI_4K_BOUNDARY) - {1'b0, address};
    return span >> size;
  endfunction

endpackage

// File: rtl/axi_rd_burst_master_burst_calc.sv
// Combinational burst sizing: min(remaining, MAX_LEN, beats to the 4 KB boundary).
module axi_burst_calc
  import axi_rd_burst_master_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic [11:0] address,  // only the page offset matters
  input  logic [15:0] remaining,
  input  AxiSize_t    size,
  output logic [8:0]  burst_beats
);

  logic [12:0] to_4k;

  assign to_4k = axiBeatsTo4k(address, size);

  always_comb begin
    burst_beats = 9'(MAX_LEN);
    if (remaining < 16'(MAX_LEN)) begin
      burst_beats = remaining[8:0];
    end
    if (to_4k < {4'b0, burst_beats}) begin
      burst_beats = to_4k[8:0];
    end
  end

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: splits one command into INCR bursts, streams R data through
// unchanged and reports a single sticky response per command.
module axi_rd_burst_master
  import axi_rd_burst_master_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_LEN         = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  input  logic [ADDR_W-1:0] ctrl_address,
  input  logic [15:0]       ctrl_bytes,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              status_valid,
  output logic [1:0]        status_resp
);

  localparam int unsigned BytesPerBeat = DATA_W / 8;
  localparam AxiSize_t    BeatSize     = AxiSize_t'(3'($clog2(BytesPerBeat)));
  localparam int unsigned OutW         = $clog2(MAX_OUTSTANDING + 1);

  AxiRdMasterState_t state_q;
  logic [ADDR_W-1:0] addr_q, m_araddr_q;
  logic [15:0]       remaining_q;
  logic [OutW-1:0]   outstanding_q;
  logic [8:0]        cur_beats_q, burst_beats;
  logic [7:0]        m_arlen_q;
  logic              m_arvalid_q, ctrl_ready_q, status_valid_q;
  AxiResp_t          resp_q;
  logic              ar_hs, r_hs, rlast_hs, misaligned;

  axi_burst_calc #(
    .MAX_LEN (MAX_LEN)
  ) u_burst_calc (
    .address     (addr_q[11:0]),
    .remaining   (remaining_q),
    .size        (BeatSize),
    .burst_beats (burst_beats)
  );

  assign ar_hs      = m_arvalid_q && m_arready;
  assign r_hs       = m_rvalid && out_ready;
  assign rlast_hs   = r_hs && m_rlast;
  assign misaligned = (ctrl_address & ADDR_W'(BytesPerBeat - 1)) != '0;

  // R channel is a zero-latency pass-through.
  assign m_rready  = out_ready;
  assign out_valid = m_rvalid;
  assign out_data  = m_rdata;
  assign out_last  = m_rlast && (outstanding_q == OutW'(1)) && (remaining_q == '0);

  assign ctrl_ready   = ctrl_ready_q;
  assign m_araddr     = m_araddr_q;
  assign m_arlen      = m_arlen_q;
  assign m_arsize     = BeatSize;
  assign m_arburst    = INCR;
  assign m_arvalid    = m_arvalid_q;
  assign status_valid = status_valid_q;
  assign status_resp  = resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ctrl_ready_q   <= 1'b1;
      m_arvalid_q    <= 1'b0;
      m_araddr_q     <= '0;
      m_arlen_q      <= '0;
      cur_beats_q    <= '0;
      addr_q         <= '0;
      remaining_q    <= '0;
      outstanding_q  <= '0;
      resp_q         <= OKAY;
      status_valid_q <= 1'b0;
    end else begin
      status_valid_q <= 1'b0;
      if (ar_hs && !rlast_hs) begin
        outstanding_q <= outstanding_q + OutW'(1);
      end else if (!ar_hs && rlast_hs) begin
        outstanding_q <= outstanding_q - OutW'(1);
      end
      // First error is sticky; every beat is still forwarded.
      if (r_hs && axiSuccess(resp_q) && !axiSuccess(AxiResp_t'(m_rresp))) begin
        resp_q <= AxiResp_t'(m_rresp);
      end

      case (state_q)
        StIdle: begin
          if (ctrl_valid && ctrl_ready_q) begin
            ctrl_ready_q <= 1'b0;
            addr_q       <= ctrl_address;
            resp_q       <= OKAY;
            if (ctrl_bytes == '0) begin
              remaining_q <= '0;
              state_q     <= StStatus;
            end else if (misaligned) begin
              remaining_q <= '0;
              resp_q      <= SLVERR;
              state_q     <= StStatus;
            end else begin
              remaining_q <= axiBeats(ctrl_bytes, BeatSize);
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          if (!m_arvalid_q) begin
            if (outstanding_q < OutW'(MAX_OUTSTANDING)) begin
              m_arvalid_q <= 1'b1;
              m_araddr_q  <= addr_q;
              m_arlen_q   <= 8'(burst_beats - 9'd1);
              cur_beats_q <= burst_beats;
            end
          end else if (m_arready) begin
            m_arvalid_q <= 1'b0;
            addr_q      <= addr_q + (ADDR_W'(cur_beats_q) << BeatSize);
            remaining_q <= remaining_q - 16'(cur_beats_q);
            if (remaining_q == 16'(cur_beats_q)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (outstanding_q == '0) begin
            state_q <= StStatus;
          end
        end
        StStatus: begin
          status_valid_q <= 1'b1;
          ctrl_ready_q   <= 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Scoreboard bench: a randomly stalling AXI slave returns address-derived data,
// expected AR/beat/status records are queued at command time and popped as the DUT responds.
module tb_axi_rd_burst_master;

  localparam logic [1:0] R_OKAY = 2'd0, R_EXOKAY = 2'd1, R_SLVERR = 2'd2, R_DECERR = 2'd3;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_valid, ctrl_ready;
  logic [31:0] ctrl_address;
  logic [15:0] ctrl_bytes;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic [31:0] out_data;
  logic        out_last, out_valid, out_ready;
  logic        status_valid;
  logic [1:0]  status_resp;

  axi_rd_burst_master #(
    .DATA_W          (32),
    .ADDR_W          (32),
    .MAX_LEN         (16),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_valid   (ctrl_valid),
    .ctrl_ready   (ctrl_ready),
    .ctrl_address (ctrl_address),
    .ctrl_bytes   (ctrl_bytes),
    .m_araddr     (m_araddr),
    .m_arlen      (m_arlen),
    .m_arsize     (m_arsize),
    .m_arburst    (m_arburst),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .m_rdata      (m_rdata),
    .m_rresp      (m_rresp),
    .m_rlast      (m_rlast),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .status_valid (status_valid),
    .status_resp  (status_resp)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [31:0] data; logic last;} beat_t;
  typedef struct {logic [1:0] resp; int lat;} st_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  st_t   exp_st[$];
  ar_t   slv_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Slave error injection, indexed by beat number within the command.
  logic [1:0] resp_dflt = R_OKAY;
  int         err_idx1 = -1, err_idx2 = -1;
  logic [1:0] err_resp1 = R_OKAY, err_resp2 = R_OKAY;

  // Monitor-owned state.
  int          cyc = 0, acc_cyc = 0, outst = 0, cmd_beat = 0;
  logic        r_fire = 1'b0, ar_wait = 1'b0;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;
  ar_t         e_ar;
  beat_t       e_b;
  st_t         e_st;

  // Slave-owned state.
  int          bib = 0;
  ar_t         cur;
  logic [31:0] ba;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Reference split of a command into bursts, beats and a final status.
  task automatic push_model(input logic [31:0] addr, input logic [15:0] bytes);
    int beats, rem, n, to4k, j;
    logic [31:0] a;
    logic [1:0]  resp;
    beats = (int'(bytes) + 3) / 4;
    if (bytes == 16'd0) begin
      exp_st.push_back('{R_OKAY, 2});
    end else if (addr[1:0] != 2'b00) begin
      exp_st.push_back('{R_SLVERR, 2});
    end else begin
      resp = R_OKAY;
      if (err_idx1 >= 0 && err_idx1 < beats) resp = err_resp1;
      else if (err_idx2 >= 0 && err_idx2 < beats) resp = err_resp2;
      a   = addr;
      rem = beats;
      while (rem > 0) begin
        to4k = (4096 - int'(a & 32'hFFF)) / 4;
        n = rem;
        if (n > 16) n = 16;
        if (n > to4k) n = to4k;
        exp_ar.push_back('{a, 8'(n - 1)});
        for (j = 0; j < n; j++) begin
          exp_beat.push_back('{dfun(a + 32'(4 * j)), (rem == n) && (j == n - 1)});
        end
        a   = a + 32'(4 * n);
        rem = rem - n;
      end
      exp_st.push_back('{resp, -1});
    end
  endtask

  task automatic drive_cmd(input logic [31:0] addr, input logic [15:0] bytes);
    int t;
    t = 0;
    @(posedge clk);
    #2;
    while (!ctrl_ready && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("ctrl_ready_before_cmd", ctrl_ready, 1);
    ctrl_address = addr;
    ctrl_bytes   = bytes;
    ctrl_valid   = 1'b1;
    @(posedge clk);
    #2;
    ctrl_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [15:0] bytes);
    int t;
    push_model(addr, bytes);
    drive_cmd(addr, bytes);
    t = 0;
    while ((exp_st.size() != 0 || exp_beat.size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("cmd_done_in_time", t < 3000, 1);
    repeat (4) @(posedge clk);
  endtask

  // Monitor: samples on the falling edge, between the driving and active edges.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        outst = 0; cmd_beat = 0; ar_wait = 1'b0; r_fire = 1'b0;
        continue;
      end
      r_fire = m_rvalid && m_rready;
      if (ar_wait) begin
        check("ar_hold_valid", m_arvalid, 1);
        check("ar_hold_addr", m_araddr, hold_addr);
        check("ar_hold_len", m_arlen, hold_len);
      end
      ar_wait   = m_arvalid && !m_arready;
      hold_addr = m_araddr;
      hold_len  = m_arlen;
      if (ctrl_valid && ctrl_ready) begin
        acc_cyc  = cyc;
        cmd_beat = 0;
      end
      if (r_fire) begin
        check("out_valid", out_valid, 1);
        if (exp_beat.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          e_b = exp_beat.pop_front();
          check("out_data", out_data, e_b.data);
          check("out_last", out_last, e_b.last);
        end
        cmd_beat++;
        if (m_rlast) outst--;
      end
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) begin
          check("ar_unexpected", 1, 0);
        end else begin
          e_ar = exp_ar.pop_front();
          check("araddr", m_araddr, e_ar.addr);
          check("arlen", m_arlen, e_ar.len);
        end
        check("arsize", m_arsize, 3'd2);
        check("arburst", m_arburst, 2'd1);
        slv_q.push_back('{m_araddr, m_arlen});
        outst++;
        check("outstanding_le_max", outst > MAX_OUT, 0);
      end
      if (status_valid) begin
        if (exp_st.size() == 0) begin
          check("status_unexpected", 1, 0);
        end else begin
          e_st = exp_st.pop_front();
          check("status_resp", status_resp, e_st.resp);
          if (e_st.lat >= 0) check("status_latency", cyc - acc_cyc, e_st.lat);
        end
      end
    end
  end

  // AXI read slave with random stalls and random downstream backpressure.
  initial begin
    m_arready = 1'b0; out_ready = 1'b0; m_rvalid = 1'b0;
    m_rdata = '0; m_rresp = R_OKAY; m_rlast = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        slv_q.delete();
        m_rvalid = 1'b0; m_rlast = 1'b0; bib = 0;
      end else begin
        if (m_rvalid && r_fire) begin
          if (m_rlast) begin
            void'(slv_q.pop_front());
            bib = 0;
          end else begin
            bib++;
          end
          m_rvalid = 1'b0;
        end
        m_arready = ($urandom_range(0, 2) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        if (!m_rvalid && slv_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          cur     = slv_q[0];
          ba      = cur.addr + 32'(bib * 4);
          m_rdata = dfun(ba);
          m_rlast = (bib == int'(cur.len));
          m_rresp = (cmd_beat == err_idx1) ? err_resp1 :
                    (cmd_beat == err_idx2) ? err_resp2 : resp_dflt;
          m_rvalid = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0; ctrl_valid = 1'b0; ctrl_address = '0; ctrl_bytes = '0;
    #12;
    check("rst_ctrl_ready", ctrl_ready, 1);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_status_valid", status_valid, 0);
    check("rst_status_resp", status_resp, R_OKAY);
    check("rst_araddr", m_araddr, 0);
    check("rst_arlen", m_arlen, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    run_cmd(32'h0000_1000, 16'd64);
    run_cmd(32'h0000_0FF0, 16'd32);
    resp_dflt = R_EXOKAY;
    run_cmd(32'h0000_2000, 16'd10);
    resp_dflt = R_OKAY;
    run_cmd(32'h0000_1002, 16'd16);
    run_cmd(32'h0000_1000, 16'd0);

    err_idx1 = 4; err_resp1 = R_SLVERR;
    err_idx2 = 8; err_resp2 = R_DECERR;
    run_cmd(32'h0000_5000, 16'd64);
    err_idx1 = -1; err_idx2 = -1;

    run_cmd(32'h0000_3000, 16'd256);

    // Reset while bursts are still draining.
    push_model(32'h0000_4000, 16'd256);
    drive_cmd(32'h0000_4000, 16'd256);
    t = 0;
    while (!(exp_ar.size() == 0 && outst > 0) && t < 3000) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("reached_drain", t < 3000, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_arvalid", m_arvalid, 0);
    check("midrst_ctrl_ready", ctrl_ready, 1);
    check("midrst_status_valid", status_valid, 0);
    exp_beat.delete();
    exp_st.delete();
    exp_ar.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    run_cmd(32'h0000_1000, 16'd64);

    check("scoreboard_empty", exp_beat.size() + exp_ar.size() + exp_st.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
